mem_test_gen: RTL and testbench
===============================

MEM_TEST_GEN -- requirements
Module: mem_test_gen

Interface
REQ-001 Parameter ADDR_W, default 27, byte-address width of the memory-subsystem CPU port.
REQ-002 Parameter NUM_WORDS, default 1024, number of 32-bit words exercised per run; legal range 1..2^(ADDR_W-2).
REQ-003 Parameter BASE_ADDR, default 0, first byte address tested; must be 4-byte aligned.
REQ-004 Parameter SEED, default 32'hA5A5_5A5A, pattern seed.
REQ-005 Parameter TIMEOUT, default 4096, maximum cycles spent waiting for any single transaction.
REQ-006 Port list, one per line, in this order:
  clk_i  in  1  single clock; all logic is rising-edge on clk_i.
  reset_b_i  in  1  asynchronous active-low reset.
  start_i  in  1  level; a 0->1 edge seen in IDLE or DONE begins a run.
  ready_i  in  1  memory subsystem ready (calibration complete, can accept a strobe).
  transaction_complete_i  in  1  one-cycle pulse ending the outstanding transaction.
  data_i  in  32  read data; valid in the transaction_complete_i cycle.
  addr_o  out  ADDR_W  byte address of the current transaction.
  width_o  out  2  access size; always 2'b10 (32-bit word).
  data_o  out  32  write data.
  wstrobe_o  out  1  one-cycle write request pulse.
  rstrobe_o  out  1  one-cycle read request pulse.
  busy_o  out  1  high from run start until DONE or ERROR.
  done_o  out  1  high in DONE; held until the next run starts.
  pass_o  out  1  high in DONE when err_count_o == 0.
  timeout_o  out  1  high in ERROR (a transaction never completed).
  err_count_o  out  16  saturating count of miscompares this run.
  fail_addr_o  out  ADDR_W  address of the first miscompare this run.

Function
REQ-007 States: IDLE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT, DONE, ERROR.
REQ-008 IDLE/DONE/ERROR -> WR_REQ on start_i rising edge; this clears the word index, err_count_o, fail_addr_o, done_o, pass_o and timeout_o, and sets busy_o.
REQ-009 Pattern for word index i (0..NUM_WORDS-1): SEED XOR {i[15:0], ~i[15:0]}; address = BASE_ADDR + 4*i, truncated to ADDR_W bits (wraps modulo 2^ADDR_W).
REQ-010 WR_REQ: while ready_i is low, no strobe is issued and the state holds; when ready_i is high, wstrobe_o is pulsed for exactly one cycle with addr_o/data_o valid, then -> WR_WAIT.
REQ-011 addr_o, data_o and width_o are held stable from the strobe cycle through the transaction_complete_i cycle.
REQ-012 WR_WAIT: on transaction_complete_i, if i == NUM_WORDS-1 then i <= 0 and -> RD_REQ, else i <= i+1 and -> WR_REQ.
REQ-013 RD_REQ: same ready_i rule as WR_REQ; rstrobe_o is pulsed one cycle, then -> RD_WAIT.
REQ-014 RD_WAIT: on transaction_complete_i, data_i is compared to the expected pattern in that same cycle; on mismatch err_count_o increments (saturating at 16'hFFFF), and fail_addr_o is captured only if this is the first mismatch of the run.
REQ-015 RD_WAIT: after the compare, last word -> DONE, otherwise i <= i+1 and -> RD_REQ.
REQ-016 At most one transaction is outstanding; wstrobe_o and rstrobe_o are never high together and never high outside WR_REQ/RD_REQ.
REQ-017 A cycle counter clears on every strobe; if it reaches TIMEOUT in WR_WAIT or RD_WAIT -> ERROR (timeout_o=1, busy_o=0, done_o=0).
REQ-018 transaction_complete_i arriving in any state other than WR_WAIT/RD_WAIT is ignored.
REQ-019 A start_i edge during a run (busy_o=1) is ignored.
REQ-020 DONE: done_o=1, busy_o=0, pass_o=(err_count_o==0); state holds until the next start_i edge.

Reset
REQ-021 reset_b_i low asynchronously forces IDLE; all outputs are 0 except width_o=2'b10; word index, timeout counter and the start_i edge register are cleared.
REQ-022 Reset asserted mid-transaction abandons the run; no strobe is issued in the cycle reset deasserts, and a new start_i edge is required to begin again.

Verification
REQ-023 NUM_WORDS=4, ideal memory model (completes 3 cycles after a strobe) -> 4 wstrobes at 0x0,0x4,0x8,0xC with data 0xA5A55A5A^{i,~i}, then 4 rstrobes, then done_o=1, pass_o=1, err_count_o=0.
REQ-024 Model corrupts the read of 0x8 (bit 0 flipped) -> done_o=1, pass_o=0, err_count_o=1, fail_addr_o=0x8.
REQ-025 ready_i held low for 100 cycles after start_i -> no strobes during that time; the run completes normally once ready_i rises.
REQ-026 Model never completes the 2nd write, TIMEOUT=16 -> timeout_o=1 exactly 16 cycles after the strobe, busy_o=0, no further strobes.
REQ-027 reset_b_i pulsed low during RD_WAIT -> all outputs immediately 0 (width_o=2'b10); a subsequent start_i edge reruns from BASE_ADDR and passes.
REQ-028 Spurious transaction_complete_i in IDLE plus start_i toggled mid-run -> no state change from either; exactly NUM_WORDS writes and NUM_WORDS reads are issued.

Source files
------------

// File: rtl/mem_test_gen.sv
// Memory subsystem self-test: writes a seeded pattern to NUM_WORDS words,
// reads them back, and reports a pass/fail/timeout verdict.
module mem_test_gen #(
    parameter int unsigned       ADDR_W    = 27,
    parameter int unsigned       NUM_WORDS = 1024,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter logic [31:0]       SEED      = 32'hA5A5_5A5A,
    parameter int unsigned       TIMEOUT   = 4096
) (
    input  logic              clk_i,
    input  logic              reset_b_i,
    input  logic              start_i,
    input  logic              ready_i,
    input  logic              transaction_complete_i,
    input  logic [31:0]       data_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic [1:0]        width_o,
    output logic [31:0]       data_o,
    output logic              wstrobe_o,
    output logic              rstrobe_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              pass_o,
    output logic              timeout_o,
    output logic [15:0]       err_count_o,
    output logic [ADDR_W-1:0] fail_addr_o
);

    typedef enum logic [2:0] {
        StIdle, StWrReq, StWrWait, StRdReq, StRdWait, StDone, StError
    } state_e;

    state_e            state_q, state_d;
    logic [31:0]       idx_q, idx_d;
    logic [31:0]       cnt_q, cnt_d;
    logic [15:0]       err_q, err_d;
    logic [ADDR_W-1:0] fail_q, fail_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       data_q, data_d;
    logic              start_q;
    logic              start_edge;
    logic              last_word;
    logic              expired;
    logic              running_d;

    function automatic logic [31:0] pattern(input logic [31:0] i);
        return SEED ^ {i[15:0], ~i[15:0]};
    endfunction

    // Address arithmetic wraps modulo 2^ADDR_W.
    function automatic logic [ADDR_W-1:0] word_addr(input logic [31:0] i);
        return BASE_ADDR + ADDR_W'({i, 2'b00});
    endfunction

    assign start_edge = start_i & ~start_q;
    assign last_word  = (idx_q == NUM_WORDS - 1);
    // Fires so that ERROR is visible exactly TIMEOUT cycles after the strobe.
    assign expired    = ((cnt_q + 32'd2) >= TIMEOUT);

    // Next-state, strobe generation and compare logic.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        fail_d    = fail_q;
        wstrobe_o = 1'b0;
        rstrobe_o = 1'b0;
        unique case (state_q)
            StIdle, StDone, StError: begin
                if (start_edge) begin
                    state_d = StWrReq;
                    idx_d   = '0;
                    err_d   = '0;
                    fail_d  = '0;
                end
            end
            StWrReq: begin
                if (ready_i) begin
                    wstrobe_o = 1'b1;
                    cnt_d     = '0;
                    state_d   = StWrWait;
                end
            end
            StWrWait: begin
                cnt_d = cnt_q + 32'd1;
                if (transaction_complete_i) begin
                    idx_d   = last_word ? '0 : idx_q + 32'd1;
                    state_d = last_word ? StRdReq : StWrReq;
                end else if (expired) begin
                    state_d = StError;
                end
            end
            StRdReq: begin
                if (ready_i) begin
                    rstrobe_o = 1'b1;
                    cnt_d     = '0;
                    state_d   = StRdWait;
                end
            end
            StRdWait: begin
                cnt_d = cnt_q + 32'd1;
                if (transaction_complete_i) begin
                    if (data_i != data_q) begin
                        if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
                        if (err_q == 16'd0) fail_d = addr_q;
                    end
                    idx_d   = last_word ? idx_q : idx_q + 32'd1;
                    state_d = last_word ? StDone : StRdReq;
                end else if (expired) begin
                    state_d = StError;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Address/data follow the word index only while a run is active.
    always_comb begin
        running_d = (state_d == StWrReq) || (state_d == StWrWait) ||
                    (state_d == StRdReq) || (state_d == StRdWait);
        addr_d    = running_d ? word_addr(idx_d) : addr_q;
        data_d    = running_d ? pattern(idx_d) : data_q;
    end

    // State and datapath registers.
    always_ff @(posedge clk_i or negedge reset_b_i) begin
        if (!reset_b_i) begin
            state_q <= StIdle;
            idx_q   <= '0;
            cnt_q   <= '0;
            err_q   <= '0;
            fail_q  <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            fail_q  <= fail_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            start_q <= start_i;
        end
    end

    // Status outputs decoded from the registered state.
    always_comb begin
        busy_o      = (state_q == StWrReq) || (state_q == StWrWait) ||
                      (state_q == StRdReq) || (state_q == StRdWait);
        done_o      = (state_q == StDone);
        pass_o      = (state_q == StDone) && (err_q == 16'd0);
        timeout_o   = (state_q == StError);
        err_count_o = err_q;
        fail_addr_o = fail_q;
        addr_o      = addr_q;
        data_o      = data_q;
        width_o     = 2'b10;
    end

endmodule

// File: tb/tb_mem_test_gen.sv
// Bench for mem_test_gen: memory model plus strobe scoreboard, one task per scenario.
module tb_mem_test_gen;

    localparam int unsigned AW = 27;
    localparam int unsigned NW = 4;

    logic          clk = 1'b0;
    logic          reset_b = 1'b1;
    logic          start = 1'b0;
    logic          ready = 1'b1;
    logic          model_tc = 1'b0;
    logic          spurious_tc = 1'b0;
    logic          tc;
    logic [31:0]   rd_data = '0;
    logic [AW-1:0] addr_o;
    logic [1:0]    width_o;
    logic [31:0]   data_o;
    logic          wstrobe_o, rstrobe_o, busy_o, done_o, pass_o, timeout_o;
    logic [15:0]   err_count_o;
    logic [AW-1:0] fail_addr_o;

    assign tc = model_tc | spurious_tc;

    mem_test_gen #(
        .ADDR_W(AW), .NUM_WORDS(NW), .BASE_ADDR('0), .SEED(32'hA5A5_5A5A), .TIMEOUT(16)
    ) dut (
        .clk_i(clk), .reset_b_i(reset_b), .start_i(start), .ready_i(ready),
        .transaction_complete_i(tc), .data_i(rd_data), .addr_o(addr_o), .width_o(width_o),
        .data_o(data_o), .wstrobe_o(wstrobe_o), .rstrobe_o(rstrobe_o), .busy_o(busy_o),
        .done_o(done_o), .pass_o(pass_o), .timeout_o(timeout_o), .err_count_o(err_count_o),
        .fail_addr_o(fail_addr_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            wr;
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } exp_t;

    exp_t          sb_q[$];
    logic [31:0]   mem[int];
    int            n_chk = 0;
    int            n_pass = 0;
    int            cyc = 0;
    int            wr_seen = 0;
    int            rd_seen = 0;
    int            last_strobe_cyc = 0;
    int            drop_wr_num = 0;
    bit            corrupt_en = 0;
    logic [AW-1:0] corrupt_addr = '0;
    int            model_cnt = 0;
    logic [AW-1:0] held_addr = '0;
    logic [31:0]   held_data = '0;
    bit            held_wr = 0;

    always @(posedge clk) cyc++;

    // Memory model (completes 3 cycles after each strobe) and strobe scoreboard.
    always @(negedge clk) begin
        if (!reset_b) begin
            model_cnt = 0;
            model_tc  = 1'b0;
        end else begin
            model_tc = 1'b0;
            if (wstrobe_o || rstrobe_o) begin
                exp_t e;
                last_strobe_cyc = cyc;
                n_chk++;
                if (wstrobe_o && rstrobe_o || width_o !== 2'b10)
                    $display("FAIL strobe_form: ws=%b rs=%b width=%b, want one strobe, width 10",
                             wstrobe_o, rstrobe_o, width_o);
                else n_pass++;
                n_chk++;
                if (sb_q.size() == 0) begin
                    $display("FAIL unexpected_strobe: ws=%b addr=%h, want no strobe",
                             wstrobe_o, addr_o);
                end else begin
                    n_pass++;
                    e = sb_q.pop_front();
                    n_chk++;
                    if (e.wr !== wstrobe_o || addr_o !== e.addr)
                        $display("FAIL strobe_kind_addr: wr=%b addr=%h, want wr=%b addr=%h",
                                 wstrobe_o, addr_o, e.wr, e.addr);
                    else n_pass++;
                    if (e.wr) begin
                        n_chk++;
                        if (data_o !== e.data)
                            $display("FAIL write_data: got %h want %h at %h",
                                     data_o, e.data, addr_o);
                        else n_pass++;
                    end
                end
                held_addr = addr_o;
                held_data = data_o;
                held_wr   = wstrobe_o;
                model_cnt = 3;
                if (wstrobe_o) begin
                    wr_seen++;
                    mem[int'(addr_o)] = data_o;
                    if (wr_seen == drop_wr_num) model_cnt = 0;
                end else begin
                    rd_seen++;
                end
            end else if (model_cnt > 0) begin
                model_cnt--;
                if (model_cnt == 0) begin
                    n_chk++;
                    if (addr_o !== held_addr || data_o !== held_data)
                        $display("FAIL hold_stable: addr=%h data=%h, want addr=%h data=%h",
                                 addr_o, data_o, held_addr, held_data);
                    else n_pass++;
                    if (!held_wr) begin
                        rd_data = mem.exists(int'(held_addr)) ? mem[int'(held_addr)] : 32'h0;
                        if (corrupt_en && held_addr == corrupt_addr) rd_data[0] = ~rd_data[0];
                    end
                    model_tc = 1'b1;
                end
            end
        end
    end

    function automatic logic [31:0] pat(input int i);
        logic [31:0] iv;
        iv = i;
        return 32'hA5A5_5A5A ^ {iv[15:0], ~iv[15:0]};
    endfunction

    task automatic push_run(input int n_wr, input int n_rd);
        for (int i = 0; i < n_wr; i++) sb_q.push_back('{1'b1, AW'(4 * i), pat(i)});
        for (int i = 0; i < n_rd; i++) sb_q.push_back('{1'b0, AW'(4 * i), 32'h0});
        wr_seen = 0;
        rd_seen = 0;
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        repeat (2) @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1 reset_b = 1'b0;
        repeat (3) @(negedge clk);
        reset_b = 1'b1;
        sb_q.delete();
    endtask

    task automatic wait_end(input int budget, input string name);
        bit seen;
        seen = 0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (done_o || timeout_o) begin
                seen = 1;
                break;
            end
        end
        n_chk++;
        if (!seen) $display("FAIL %s_end: busy=%b after %0d cycles, want done", name, busy_o, budget);
        else n_pass++;
    endtask

    task automatic check_verdict(input string name, input logic exp_pass, input logic [15:0] exp_err,
                                 input logic [AW-1:0] exp_fail);
        n_chk++;
        if ({done_o, busy_o, timeout_o, pass_o} !== {3'b100, exp_pass} || err_count_o !== exp_err)
            $display("FAIL %s_verdict: done=%b busy=%b to=%b pass=%b err=%0d, want 1 0 0 %b err=%0d",
                     name, done_o, busy_o, timeout_o, pass_o, err_count_o, exp_pass, exp_err);
        else n_pass++;
        n_chk++;
        if (fail_addr_o !== exp_fail)
            $display("FAIL %s_fail_addr: got %h want %h", name, fail_addr_o, exp_fail);
        else n_pass++;
        n_chk++;
        if (sb_q.size() != 0)
            $display("FAIL %s_missing_strobes: %0d outstanding, want 0", name, sb_q.size());
        else n_pass++;
    endtask

    task automatic test_reset();
        n_chk++;
        if ({busy_o, done_o, pass_o, timeout_o, wstrobe_o, rstrobe_o} !== 6'b0)
            $display("FAIL reset_flags: got %b want 000000",
                     {busy_o, done_o, pass_o, timeout_o, wstrobe_o, rstrobe_o});
        else n_pass++;
        n_chk++;
        if (addr_o !== '0 || data_o !== '0 || err_count_o !== '0 || fail_addr_o !== '0
            || width_o !== 2'b10)
            $display("FAIL reset_values: addr=%h data=%h err=%h fail=%h width=%b, want 0s/10",
                     addr_o, data_o, err_count_o, fail_addr_o, width_o);
        else n_pass++;
    endtask

    task automatic test_basic();
        push_run(NW, NW);
        pulse_start();
        wait_end(500, "basic");
        check_verdict("basic", 1'b1, 16'd0, '0);
    endtask

    task automatic test_corrupt();
        corrupt_en = 1;
        corrupt_addr = AW'(8);
        push_run(NW, NW);
        pulse_start();
        wait_end(500, "corrupt");
        check_verdict("corrupt", 1'b0, 16'd1, AW'(8));
        corrupt_en = 0;
    endtask

    task automatic test_ready_low();
        ready = 1'b0;
        push_run(NW, NW);
        pulse_start();
        repeat (100) @(negedge clk);
        n_chk++;
        if (wr_seen != 0 || rd_seen != 0 || busy_o !== 1'b1)
            $display("FAIL ready_low_hold: wr=%0d rd=%0d busy=%b, want 0 0 1",
                     wr_seen, rd_seen, busy_o);
        else n_pass++;
        ready = 1'b1;
        wait_end(500, "ready_low");
        check_verdict("ready_low", 1'b1, 16'd0, '0);
    endtask

    task automatic test_timeout();
        bit seen;
        int delta;
        seen = 0;
        delta = -1;
        drop_wr_num = 2;
        push_run(2, 0);
        pulse_start();
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (timeout_o) begin
                seen = 1;
                delta = cyc - last_strobe_cyc;
                break;
            end
        end
        n_chk++;
        if (!seen || delta != 16)
            $display("FAIL timeout_latency: seen=%b after %0d cycles, want 16", seen, delta);
        else n_pass++;
        n_chk++;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || pass_o !== 1'b0)
            $display("FAIL timeout_flags: busy=%b done=%b pass=%b, want 0 0 0",
                     busy_o, done_o, pass_o);
        else n_pass++;
        repeat (20) @(negedge clk);
        n_chk++;
        if (wr_seen != 2 || rd_seen != 0 || timeout_o !== 1'b1)
            $display("FAIL timeout_quiet: wr=%0d rd=%0d to=%b, want 2 0 1",
                     wr_seen, rd_seen, timeout_o);
        else n_pass++;
        drop_wr_num = 0;
    endtask

    task automatic test_reset_mid();
        int wr_before;
        push_run(NW, NW);
        pulse_start();
        for (int k = 0; k < 500 && rd_seen < 2; k++) @(negedge clk);
        @(negedge clk);
        #1 reset_b = 1'b0;
        #1;
        n_chk++;
        if ({busy_o, done_o, pass_o, timeout_o, wstrobe_o, rstrobe_o} !== 6'b0 ||
            addr_o !== '0 || data_o !== '0 || err_count_o !== '0 || width_o !== 2'b10)
            $display("FAIL reset_mid_outputs: flags=%b addr=%h data=%h err=%h width=%b, want 0/10",
                     {busy_o, done_o, pass_o, timeout_o, wstrobe_o, rstrobe_o},
                     addr_o, data_o, err_count_o, width_o);
        else n_pass++;
        repeat (2) @(negedge clk);
        reset_b = 1'b1;
        sb_q.delete();
        wr_before = wr_seen;
        repeat (4) @(negedge clk);
        n_chk++;
        if (wr_seen != wr_before || busy_o !== 1'b0)
            $display("FAIL reset_mid_idle: strobes=%0d busy=%b, want none, busy 0",
                     wr_seen - wr_before, busy_o);
        else n_pass++;
        push_run(NW, NW);
        pulse_start();
        wait_end(500, "reset_mid");
        check_verdict("reset_mid", 1'b1, 16'd0, '0);
    endtask

    task automatic test_spurious();
        do_reset();
        wr_seen = 0;
        rd_seen = 0;
        @(negedge clk) spurious_tc = 1'b1;
        @(negedge clk) spurious_tc = 1'b0;
        repeat (3) @(negedge clk);
        n_chk++;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || wr_seen != 0)
            $display("FAIL spurious_idle: busy=%b done=%b wr=%0d, want 0 0 0",
                     busy_o, done_o, wr_seen);
        else n_pass++;
        push_run(NW, NW);
        pulse_start();
        for (int k = 0; k < 500 && wr_seen < 2; k++) @(negedge clk);
        pulse_start();
        wait_end(500, "spurious");
        n_chk++;
        if (wr_seen != NW || rd_seen != NW)
            $display("FAIL spurious_counts: wr=%0d rd=%0d, want %0d %0d", wr_seen, rd_seen, NW, NW);
        else n_pass++;
        check_verdict("spurious", 1'b1, 16'd0, '0);
    endtask

    initial begin
        do_reset();
        test_reset();
        test_basic();
        test_corrupt();
        test_ready_low();
        test_timeout();
        test_reset_mid();
        test_spurious();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
